// File: rtl/cache_pkg.sv
// Shared constants for the cache stage (acquisition -> cache -> transmit).
package cache_pkg;

    localparam int SAMPLE_W             = 16;
    localparam int BYTE_W               = 8;
    localparam bit BYTE_ORDER_MSB_FIRST = 1'b1;
    localparam int DEPTH_W_DEF          = 512;
    localparam int CNT_W_DEF            = 16;

    // Picks the byte of a stored word for the first (second=0) or second read.
    function automatic logic [BYTE_W-1:0] pick_byte(input logic [SAMPLE_W-1:0] word,
                                                    input logic                second);
        logic take_hi;
        take_hi = second ^ BYTE_ORDER_MSB_FIRST;
        return take_hi ? word[SAMPLE_W-1:BYTE_W] : word[BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/cache_sdp_ram.sv
// Simple dual-port word store: one write port, one enabled registered read port.
module cache_sdp_ram
    import cache_pkg::*;
#(
    parameter int DEPTH_W = DEPTH_W_DEF,
    parameter int AW      = $clog2(DEPTH_W)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [SAMPLE_W-1:0] wdata,
    input  logic                re,
    input  logic [AW-1:0]       raddr,
    output logic [SAMPLE_W-1:0] rdata
);

    logic [SAMPLE_W-1:0] mem [DEPTH_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sensor_cache_channel.sv
// Per-sensor circular sample cache: 16-bit words in, big-endian byte stream out,
// with byte count, empty/full and sticky overflow/underflow status.
module sensor_cache_channel
    import cache_pkg::*;
#(
    parameter int DEPTH_W = DEPTH_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                sys_clk_i,
    input  logic                rst_n_i,
    input  logic                wr_en_i,
    input  logic [SAMPLE_W-1:0] wr_din_i,
    input  logic                adc_acq_start_pluse_i,
    input  logic                sim_data_en_i,
    input  logic                rd_en_i,
    output logic [BYTE_W-1:0]   rd_dout_o,
    output logic                empty_o,
    output logic                full_o,
    output logic [CNT_W-1:0]    rd_data_count_o,
    output logic                overflow_o,
    output logic                underflow_o
);

    localparam int               AW      = $clog2(DEPTH_W);
    localparam logic [CNT_W-1:0] FULL_TH = CNT_W'(2 * DEPTH_W - 2);

    logic [SAMPLE_W-1:0] sim_cnt;
    logic                wr_stb;
    logic [SAMPLE_W-1:0] wr_data;
    logic                wr_acc;
    logic                rd_acc;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_word;
    logic                rd_lo;
    logic                dout_lo;
    logic                dout_vld;
    logic [SAMPLE_W-1:0] ram_q;
    logic [CNT_W-1:0]    cnt_nxt;

    assign wr_stb  = sim_data_en_i ? adc_acq_start_pluse_i : wr_en_i;
    assign wr_data = sim_data_en_i ? sim_cnt : wr_din_i;
    assign wr_acc  = wr_stb & ~full_o;
    assign rd_acc  = rd_en_i & ~empty_o;

    always_comb begin
        cnt_nxt = rd_data_count_o;
        if (wr_acc) cnt_nxt = cnt_nxt + CNT_W'(2);
        if (rd_acc) cnt_nxt = cnt_nxt - CNT_W'(1);
    end

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sim_cnt         <= '0;
            wr_ptr          <= '0;
            rd_word         <= '0;
            rd_lo           <= 1'b0;
            dout_lo         <= 1'b0;
            dout_vld        <= 1'b0;
            rd_data_count_o <= '0;
            empty_o         <= 1'b1;
            full_o          <= 1'b0;
            overflow_o      <= 1'b0;
            underflow_o     <= 1'b0;
        end else begin
            // Test pattern advances on every sim tick, even when the word is dropped.
            if (sim_data_en_i && adc_acq_start_pluse_i) sim_cnt <= sim_cnt + SAMPLE_W'(1);
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (wr_stb && full_o) overflow_o <= 1'b1;
            if (rd_en_i && empty_o) underflow_o <= 1'b1;
            if (rd_acc) begin
                dout_lo  <= rd_lo;
                dout_vld <= 1'b1;
                rd_lo    <= ~rd_lo;
                // The word slot is released only once its second byte has gone out.
                if (rd_lo) rd_word <= rd_word + AW'(1);
            end
            rd_data_count_o <= cnt_nxt;
            empty_o         <= (cnt_nxt == '0);
            full_o          <= (cnt_nxt > FULL_TH);
        end
    end

    cache_sdp_ram #(
        .DEPTH_W (DEPTH_W),
        .AW      (AW)
    ) u_ram (
        .clk   (sys_clk_i),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .re    (rd_acc),
        .raddr (rd_word),
        .rdata (ram_q)
    );

    // RAM output register has no reset; gate it so reset reads back as zero.
    assign rd_dout_o = dout_vld ? pick_byte(ram_q, dout_lo) : '0;

endmodule

// File: tb/tb_sensor_cache_channel.sv
// Bench for sensor_cache_channel: vector table, corner sequences, random vs byte-queue model.
module tb_sensor_cache_channel;

    localparam int DEPTH = 8;
    localparam int CW    = 16;

    logic          sys_clk_i = 1'b0;
    logic          rst_n_i;
    logic          wr_en_i;
    logic [15:0]   wr_din_i;
    logic          adc_acq_start_pluse_i;
    logic          sim_data_en_i;
    logic          rd_en_i;
    logic [7:0]    rd_dout_o;
    logic          empty_o;
    logic          full_o;
    logic [CW-1:0] rd_data_count_o;
    logic          overflow_o;
    logic          underflow_o;

    sensor_cache_channel #(.DEPTH_W(DEPTH), .CNT_W(CW)) dut (
        .sys_clk_i             (sys_clk_i),
        .rst_n_i               (rst_n_i),
        .wr_en_i               (wr_en_i),
        .wr_din_i              (wr_din_i),
        .adc_acq_start_pluse_i (adc_acq_start_pluse_i),
        .sim_data_en_i         (sim_data_en_i),
        .rd_en_i               (rd_en_i),
        .rd_dout_o             (rd_dout_o),
        .empty_o               (empty_o),
        .full_o                (full_o),
        .rd_data_count_o       (rd_data_count_o),
        .overflow_o            (overflow_o),
        .underflow_o           (underflow_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: the cache is a queue of bytes in read order.
    logic [7:0]  mq[$];
    logic [7:0]  m_dout;
    logic        m_ovf;
    logic        m_unf;
    logic [15:0] m_sim;

    typedef struct {
        logic        rst_n;
        logic        wr_en;
        logic [15:0] din;
        logic        acq;
        logic        sim;
        logic        rd_en;
        logic [7:0]  dout;
        logic        empty;
        logic        full;
        logic [15:0] cnt;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mkv(logic r, logic w, logic [15:0] d, logic a, logic s, logic rd,
                                 logic [7:0] o, logic e, logic f, logic [15:0] c, logic ov, logic un);
        vec_t v;
        v.rst_n = r; v.wr_en = w; v.din = d; v.acq = a; v.sim = s; v.rd_en = rd;
        v.dout = o; v.empty = e; v.full = f; v.cnt = c; v.ovf = ov; v.unf = un;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_dout = 8'h00;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_sim  = 16'h0000;
    endtask

    task automatic model_edge();
        logic        stb;
        logic [15:0] d;
        logic        was_full;
        logic        was_empty;
        if (!rst_n_i) begin
            model_reset();
            return;
        end
        was_full  = (mq.size() > 2 * DEPTH - 2);
        was_empty = (mq.size() == 0);
        stb = sim_data_en_i ? adc_acq_start_pluse_i : wr_en_i;
        d   = sim_data_en_i ? m_sim : wr_din_i;
        if (sim_data_en_i && adc_acq_start_pluse_i) m_sim = m_sim + 16'd1;
        if (rd_en_i) begin
            if (!was_empty) m_dout = mq.pop_front();
            else            m_unf = 1'b1;
        end
        if (stb) begin
            if (!was_full) begin
                mq.push_back(d[15:8]);
                mq.push_back(d[7:0]);
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge sys_clk_i);
        model_edge();
        #1;
    endtask

    task automatic set_in(input logic w, input logic [15:0] d, input logic a,
                          input logic s, input logic rd);
        wr_en_i = w; wr_din_i = d; adc_acq_start_pluse_i = a; sim_data_en_i = s; rd_en_i = rd;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".dout"},  rd_dout_o, m_dout);
        check({tag, ".count"}, rd_data_count_o, mq.size());
        check({tag, ".empty"}, empty_o, mq.size() == 0);
        check({tag, ".full"},  full_o, mq.size() > 2 * DEPTH - 2);
        check({tag, ".ovf"},   overflow_o, m_ovf);
        check({tag, ".unf"},   underflow_o, m_unf);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".dout"},  rd_dout_o, 8'h00);
        check({tag, ".empty"}, empty_o, 1'b1);
        check({tag, ".full"},  full_o, 1'b0);
        check({tag, ".count"}, rd_data_count_o, 16'd0);
        check({tag, ".ovf"},   overflow_o, 1'b0);
        check({tag, ".unf"},   underflow_o, 1'b0);
    endtask

    initial begin
        model_reset();
        rst_n_i = 1'b0;
        set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

        //           rst wr  din      acq sim rd   dout   emp ful cnt ovf unf
        tbl[0]  = mkv(0, 0, 16'h0000, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0);
        tbl[1]  = mkv(1, 1, 16'hA1B2, 0, 0, 0, 8'h00, 0, 0, 2, 0, 0);
        tbl[2]  = mkv(1, 0, 16'h0000, 0, 0, 1, 8'hA1, 0, 0, 1, 0, 0);
        tbl[3]  = mkv(1, 0, 16'h0000, 0, 0, 1, 8'hB2, 1, 0, 0, 0, 0);
        tbl[4]  = mkv(1, 0, 16'h0000, 0, 0, 0, 8'hB2, 1, 0, 0, 0, 0);
        tbl[5]  = mkv(1, 1, 16'hDEAD, 1, 1, 0, 8'hB2, 0, 0, 2, 0, 0);
        tbl[6]  = mkv(1, 1, 16'hDEAD, 0, 1, 0, 8'hB2, 0, 0, 2, 0, 0);
        tbl[7]  = mkv(1, 0, 16'hDEAD, 1, 1, 0, 8'hB2, 0, 0, 4, 0, 0);
        tbl[8]  = mkv(1, 1, 16'hBEEF, 0, 1, 0, 8'hB2, 0, 0, 4, 0, 0);
        tbl[9]  = mkv(1, 1, 16'hBEEF, 1, 1, 0, 8'hB2, 0, 0, 6, 0, 0);
        tbl[10] = mkv(1, 0, 16'h0000, 0, 0, 1, 8'h00, 0, 0, 5, 0, 0);
        tbl[11] = mkv(1, 0, 16'h0000, 0, 0, 1, 8'h00, 0, 0, 4, 0, 0);
        tbl[12] = mkv(1, 0, 16'h0000, 0, 0, 1, 8'h00, 0, 0, 3, 0, 0);
        tbl[13] = mkv(1, 0, 16'h0000, 0, 0, 1, 8'h01, 0, 0, 2, 0, 0);
        tbl[14] = mkv(1, 0, 16'h0000, 0, 0, 1, 8'h00, 0, 0, 1, 0, 0);
        tbl[15] = mkv(1, 0, 16'h0000, 0, 0, 1, 8'h02, 1, 0, 0, 0, 0);
        tbl[16] = mkv(1, 0, 16'h0000, 0, 0, 1, 8'h02, 1, 0, 0, 0, 1);

        repeat (5) cycle();
        check_reset_vals("reset");

        for (int i = 0; i < 17; i++) begin
            rst_n_i = tbl[i].rst_n;
            set_in(tbl[i].wr_en, tbl[i].din, tbl[i].acq, tbl[i].sim, tbl[i].rd_en);
            cycle();
            check($sformatf("vec%0d.dout", i),  rd_dout_o, tbl[i].dout);
            check($sformatf("vec%0d.empty", i), empty_o, tbl[i].empty);
            check($sformatf("vec%0d.full", i),  full_o, tbl[i].full);
            check($sformatf("vec%0d.count", i), rd_data_count_o, tbl[i].cnt);
            check($sformatf("vec%0d.ovf", i),   overflow_o, tbl[i].ovf);
            check($sformatf("vec%0d.unf", i),   underflow_o, tbl[i].unf);
        end

        // Fill to full (pointers start mid-buffer, so this also wraps), then drain.
        for (int i = 0; i < 9; i++) begin
            set_in(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, 1'b0);
            cycle();
            check_model($sformatf("fill%0d", i));
            if (i == 6) check("fill.not_full_at_7", full_o, 1'b0);
            if (i == 7) check("fill.full_at_8", full_o, 1'b1);
            if (i == 8) begin
                check("fill.ovf_at_9", overflow_o, 1'b1);
                check("fill.count_at_9", rd_data_count_o, 16'd16);
            end
        end
        for (int i = 0; i < 16; i++) begin
            set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
            cycle();
            check($sformatf("drain%0d.byte", i), rd_dout_o, (i % 2 == 0) ? 8'h01 : 8'(i / 2));
            check_model($sformatf("drain%0d", i));
        end
        check("drain.empty", empty_o, 1'b1);

        // Simultaneous write and read while a low byte is pending.
        set_in(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0); cycle();
        set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1); cycle();
        check("simul.pre_byte", rd_dout_o, 8'h12);
        check("simul.pre_count", rd_data_count_o, 16'd1);
        set_in(1'b1, 16'h5678, 1'b0, 1'b0, 1'b1); cycle();
        check("simul.pending_byte", rd_dout_o, 8'h34);
        check("simul.count", rd_data_count_o, 16'd2);
        set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1); cycle();
        check("simul.hi", rd_dout_o, 8'h56);
        cycle();
        check("simul.lo", rd_dout_o, 8'h78);
        check_model("simul.end");

        // Underflow on empty leaves the output byte alone.
        cycle();
        check("unf.dout_held", rd_dout_o, 8'h78);
        check_model("unf");

        // Mid-operation asynchronous reset.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
            cycle();
        end
        set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1); cycle();
        check_model("pre_rst");
        rst_n_i = 1'b0;
        #2;
        check_reset_vals("async_rst");
        model_reset();
        repeat (2) cycle();
        rst_n_i = 1'b1;
        cycle();
        check("post_rst.dout", rd_dout_o, 8'h00);
        check("post_rst.unf", underflow_o, 1'b1);
        check_model("post_rst");
        set_in(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0); cycle();
        set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1); cycle();
        check("post_rst.hi", rd_dout_o, 8'hBE);
        cycle();
        check("post_rst.lo", rd_dout_o, 8'hEF);
        check_model("post_rst.end");

        // Randomized traffic in write-heavy, read-heavy and balanced phases.
        for (int ph = 0; ph < 4; ph++) begin
            int wp;
            int rp;
            wp = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
            rp = (ph == 0) ? 20 : (ph == 1) ? 80 : 50;
            for (int c = 0; c < 500; c++) begin
                set_in($urandom_range(0, 99) < wp, 16'($urandom),
                       $urandom_range(0, 99) < wp, $urandom_range(0, 5) == 0,
                       $urandom_range(0, 99) < rp);
                cycle();
                check_model($sformatf("rnd%0d_%0d", ph, c));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
